lct_dead_time_filter: RTL and testbench

- Sits directly downstream of the ALCT trigger core.
- Consumes the registered best/second-best LCT outputs (valid, quality, key wire-group, accelerator flag, pattern-B flag).
- Suppresses re-triggers of the same track on neighbouring key wire-groups within a programmable dead time.
- Promotes the second LCT into the first slot when the first is suppressed, stamps a 5-bit BXN and presents two 18-bit LCT words to the TMB output mux.

---
 rtl/alct_lct_pkg.sv | 58 +++++
 rtl/lct_dead_time_filter_if.sv | 37 +++
 rtl/lct_hist_entry.sv | 47 ++++
 rtl/lct_dead_time_filter.sv | 159 +++++++++++++++
 tb/tb_lct_dead_time_filter.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alct_lct_pkg.sv
// Shared LCT definitions: word layout, history-entry type and helpers used by
// the dead-time filter and its history entries.
package alct_lct_pkg;

    localparam int unsigned LCT_W     = 18;
    localparam int unsigned KEY_W     = 7;
    localparam int unsigned Q_W       = 2;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned BXN_W     = 12;
    localparam int unsigned LCT_BXN_W = 5;
    localparam int unsigned SHOWER_W  = 2;
    localparam int unsigned SUP_W     = 16;

    // Field offsets inside an 18-bit LCT word; bit 0 is always zero.
    localparam int unsigned LCT_VALID_O = 17;
    localparam int unsigned LCT_Q_O     = 15;
    localparam int unsigned LCT_ACCEL_O = 14;
    localparam int unsigned LCT_PATB_O  = 13;
    localparam int unsigned LCT_KEY_O   = 6;
    localparam int unsigned LCT_BXN_O   = 1;

    typedef struct packed {
        logic [KEY_W-1:0] key;
        logic [Q_W-1:0]   quality;
        logic [CNT_W-1:0] cnt;
    } hist_entry_t;

    typedef struct packed {
        logic             valid;
        logic [Q_W-1:0]   quality;
        logic             accel;
        logic             patb;
        logic [KEY_W-1:0] key;
    } lct_t;

    // Two keys belong to the same track when their 8-bit unsigned distance is within tol.
    function automatic logic key_near(input logic [KEY_W-1:0] a,
                                      input logic [KEY_W-1:0] b,
                                      input int unsigned      tol);
        logic [7:0] d;
        d = (a >= b) ? (8'(a) - 8'(b)) : (8'(b) - 8'(a));
        return (32'(d) <= tol);
    endfunction

    function automatic logic [LCT_W-1:0] pack_lct(input lct_t                 l,
                                                  input logic [LCT_BXN_W-1:0] bxn);
        logic [LCT_W-1:0] w;
        w = '0;
        w[LCT_VALID_O]            = l.valid;
        w[LCT_Q_O +: Q_W]         = l.quality;
        w[LCT_ACCEL_O]            = l.accel;
        w[LCT_PATB_O]             = l.patb;
        w[LCT_KEY_O +: KEY_W]     = l.key;
        w[LCT_BXN_O +: LCT_BXN_W] = bxn;
        return w;
    endfunction

endpackage

// File: rtl/lct_dead_time_filter_if.sv
// LCT bus between the ALCT trigger core / config side and the dead-time filter.
interface lct_dead_time_filter_if;
    import alct_lct_pkg::*;

    logic                hv;
    logic [Q_W-1:0]      hp;
    logic [KEY_W-1:0]    hnp;
    logic                hfap;
    logic                hpatbp;
    logic                lv;
    logic [Q_W-1:0]      lp;
    logic [KEY_W-1:0]    lnp;
    logic                lfap;
    logic                lpatbp;
    logic [SHOWER_W-1:0] shower_int;
    logic [CNT_W-1:0]    dead_time;
    logic                bc0;
    logic [LCT_W-1:0]    lct0;
    logic [LCT_W-1:0]    lct1;
    logic [SHOWER_W-1:0] shower_o;
    logic [SUP_W-1:0]    suppressed_cnt;

    modport master (
        output hv, hp, hnp, hfap, hpatbp,
        output lv, lp, lnp, lfap, lpatbp,
        output shower_int, dead_time, bc0,
        input  lct0, lct1, shower_o, suppressed_cnt
    );

    modport slave (
        input  hv, hp, hnp, hfap, hpatbp,
        input  lv, lp, lnp, lfap, lpatbp,
        input  shower_int, dead_time, bc0,
        output lct0, lct1, shower_o, suppressed_cnt
    );

endinterface

// File: rtl/lct_hist_entry.sv
// One dead-time history entry: holds key/quality/countdown and compares both
// incoming LCTs against its pre-update state.
module lct_hist_entry
    import alct_lct_pkg::*;
#(
    parameter int unsigned KEY_TOL = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [KEY_W-1:0] load_key,
    input  logic [Q_W-1:0]   load_q,
    input  logic [CNT_W-1:0] load_cnt,
    input  logic [KEY_W-1:0] key_a,
    input  logic [Q_W-1:0]   q_a,
    input  logic [KEY_W-1:0] key_b,
    input  logic [Q_W-1:0]   q_b,
    output logic             match_a_c,
    output logic             match_b_c,
    output logic [CNT_W-1:0] cnt
);

    hist_entry_t ent;
    logic        live_c;

    assign cnt = ent.cnt;

    // A count of 1 is still live, so an entry matches during its final clock.
    always_comb begin
        live_c    = (ent.cnt != '0);
        match_a_c = live_c && key_near(key_a, ent.key, KEY_TOL) && (q_a <= ent.quality);
        match_b_c = live_c && key_near(key_b, ent.key, KEY_TOL) && (q_b <= ent.quality);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent <= '0;
        end else if (load) begin
            ent.key     <= load_key;
            ent.quality <= load_q;
            ent.cnt     <= load_cnt;
        end else if (live_c) begin
            ent.cnt <= ent.cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/lct_dead_time_filter.sv
// Suppresses same-track LCT re-triggers within a programmable dead time, promotes
// the second LCT when the best is dropped and stamps the BXN. Option: LCT_SHOWER_BYPASS_EN.
module lct_dead_time_filter
    import alct_lct_pkg::*;
#(
    parameter int unsigned KEY_TOL = 1,
    parameter int unsigned BXN_MAX = 3563
) (
    input  logic                   clk,
    input  logic                   rst_n,
    lct_dead_time_filter_if.slave  bus
);

    localparam int unsigned SUM_W = SUP_W + 1;

    lct_t             best_c;
    lct_t             second_c;
    logic [1:0]       match_h_c;
    logic [1:0]       match_l_c;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;
    logic             bypass_c;
    logic             h_acc_c;
    logic             l_acc_c;
    logic             load0_c;
    logic             load1_c;
    logic [KEY_W-1:0] load0_key_c;
    logic [KEY_W-1:0] load1_key_c;
    logic [Q_W-1:0]   load0_q_c;
    logic [Q_W-1:0]   load1_q_c;
    logic [LCT_W-1:0] lct0_c;
    logic [LCT_W-1:0] lct1_c;
    logic [1:0]       n_sup_c;
    logic [SUM_W-1:0] sup_sum_c;
    logic [SUP_W-1:0] sup_next_c;
    logic [BXN_W-1:0] bxn;

    always_comb begin
        best_c.valid    = bus.hv;
        best_c.quality  = bus.hp;
        best_c.accel    = bus.hfap;
        best_c.patb     = bus.hpatbp;
        best_c.key      = bus.hnp;
        second_c.valid   = bus.lv;
        second_c.quality = bus.lp;
        second_c.accel   = bus.lfap;
        second_c.patb    = bus.lpatbp;
        second_c.key     = bus.lnp;
    end

    lct_hist_entry #(.KEY_TOL(KEY_TOL)) u_entry0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load0_c),
        .load_key  (load0_key_c),
        .load_q    (load0_q_c),
        .load_cnt  (bus.dead_time),
        .key_a     (bus.hnp),
        .q_a       (bus.hp),
        .key_b     (bus.lnp),
        .q_b       (bus.lp),
        .match_a_c (match_h_c[0]),
        .match_b_c (match_l_c[0]),
        .cnt       (cnt0)
    );

    lct_hist_entry #(.KEY_TOL(KEY_TOL)) u_entry1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load1_c),
        .load_key  (load1_key_c),
        .load_q    (load1_q_c),
        .load_cnt  (bus.dead_time),
        .key_a     (bus.hnp),
        .q_a       (bus.hp),
        .key_b     (bus.lnp),
        .q_b       (bus.lp),
        .match_a_c (match_h_c[1]),
        .match_b_c (match_l_c[1]),
        .cnt       (cnt1)
    );

    // Accept decision; the second LCT is also dropped when it shadows an accepted best.
    always_comb begin
        bypass_c = 1'b0;
`ifdef LCT_SHOWER_BYPASS_EN
        bypass_c = |bus.shower_int;
`endif
        h_acc_c = bus.hv & (bypass_c | ~(|match_h_c));
        l_acc_c = bus.lv & (bypass_c |
                  (~(|match_l_c) & ~(h_acc_c & key_near(bus.hnp, bus.lnp, KEY_TOL))));
    end

    // Slot assignment and table load selection.
    always_comb begin
        lct0_c      = '0;
        lct1_c      = '0;
        load0_c     = 1'b0;
        load1_c     = 1'b0;
        load0_key_c = bus.hnp;
        load0_q_c   = bus.hp;
        load1_key_c = bus.lnp;
        load1_q_c   = bus.lp;

        if (h_acc_c && l_acc_c) begin
            lct0_c  = pack_lct(best_c, bxn[LCT_BXN_W-1:0]);
            lct1_c  = pack_lct(second_c, bxn[LCT_BXN_W-1:0]);
            load0_c = 1'b1;
            load1_c = 1'b1;
        end else if (h_acc_c || l_acc_c) begin
            lct0_c = h_acc_c ? pack_lct(best_c, bxn[LCT_BXN_W-1:0])
                             : pack_lct(second_c, bxn[LCT_BXN_W-1:0]);
            // Single accept overwrites the entry closer to expiry; ties go to entry 0.
            if (cnt1 < cnt0) begin
                load1_c     = 1'b1;
                load1_key_c = h_acc_c ? bus.hnp : bus.lnp;
                load1_q_c   = h_acc_c ? bus.hp  : bus.lp;
            end else begin
                load0_c     = 1'b1;
                load0_key_c = h_acc_c ? bus.hnp : bus.lnp;
                load0_q_c   = h_acc_c ? bus.hp  : bus.lp;
            end
        end
    end

    always_comb begin
        n_sup_c    = 2'(bus.hv & ~h_acc_c) + 2'(bus.lv & ~l_acc_c);
        sup_sum_c  = SUM_W'(bus.suppressed_cnt) + SUM_W'(n_sup_c);
        sup_next_c = sup_sum_c[SUP_W] ? '1 : sup_sum_c[SUP_W-1:0];
    end

    // Bunch-crossing counter; bc0 wins over the increment/wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bxn <= '0;
        end else if (bus.bc0) begin
            bxn <= '0;
        end else if (bxn == BXN_W'(BXN_MAX)) begin
            bxn <= '0;
        end else begin
            bxn <= bxn + BXN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.lct0           <= '0;
            bus.lct1           <= '0;
            bus.shower_o       <= '0;
            bus.suppressed_cnt <= '0;
        end else begin
            bus.lct0           <= lct0_c;
            bus.lct1           <= lct1_c;
            bus.shower_o       <= bus.shower_int;
            bus.suppressed_cnt <= sup_next_c;
        end
    end

endmodule

// File: tb/tb_lct_dead_time_filter.sv
// Bench for lct_dead_time_filter: directed vector table, BXN/reset sequences and
// randomized traffic against an expiry-time based reference model.
module tb_lct_dead_time_filter;

    localparam int unsigned KEY_TOL = 1;
    localparam int unsigned BXN_MAX = 3563;
    localparam logic [17:0] MASK    = 18'h3FFC1;

    typedef struct {
        logic       hv;
        logic [1:0] hq;
        logic [6:0] hk;
        logic       ha;
        logic       hb;
        logic       lv;
        logic [1:0] lq;
        logic [6:0] lk;
        logic       la;
        logic       lb;
        logic [1:0] sh;
        logic [3:0] dt;
        logic       bc0;
    } in_t;

    typedef struct {
        in_t         in;
        logic [17:0] e0;
        logic [17:0] e1;
        int          sup;
    } row_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lct_dead_time_filter_if bus ();

    lct_dead_time_filter #(.KEY_TOL(KEY_TOL), .BXN_MAX(BXN_MAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    int m_exp [2];
    int m_key [2];
    int m_q   [2];
    int cyc   = 0;
    int m_bxn = 0;
    int m_sup = 0;

    row_t rows[$];

    function automatic in_t lct_in(logic hv, logic [1:0] hq, logic [6:0] hk, logic ha, logic hb,
                                   logic lv, logic [1:0] lq, logic [6:0] lk, logic la, logic lb,
                                   logic [3:0] dt);
        in_t v;
        v.hv = hv; v.hq = hq; v.hk = hk; v.ha = ha; v.hb = hb;
        v.lv = lv; v.lq = lq; v.lk = lk; v.la = la; v.lb = lb;
        v.sh = 2'b00; v.dt = dt; v.bc0 = 1'b0;
        return v;
    endfunction

    function automatic in_t idle(logic [3:0] dt);
        return lct_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, dt);
    endfunction

    function automatic logic [17:0] w(logic v, logic [1:0] q, logic a, logic p,
                                      logic [6:0] k, logic [4:0] b);
        return {v, q, a, p, k, b, 1'b0};
    endfunction

    function automatic row_t mk_row(in_t v, logic [17:0] e0, logic [17:0] e1, int sup);
        row_t r;
        r.in = v; r.e0 = e0; r.e1 = e1; r.sup = sup;
        return r;
    endfunction

    function automatic int iabs(int x);
        return (x < 0) ? -x : x;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_exp[0] = -1; m_exp[1] = -1;
        m_key[0] = 0;  m_key[1] = 0;
        m_q[0]   = 0;  m_q[1]   = 0;
        m_sup = 0;
        m_bxn = 0;
    endtask

    // Entry i blocks through cycle m_exp[i]; it was loaded at cycle (m_exp[i] - dead_time).
    task automatic model_step(input in_t v, output logic [17:0] e0, output logic [17:0] e1,
                              output logic [1:0] es, output logic [15:0] ec);
        bit byp, hhit, lhit, hacc, lacc;
        int rem [2];
        int tgt;
        logic [4:0] b;
        byp = 1'b0;
`ifdef LCT_SHOWER_BYPASS_EN
        byp = (v.sh != 2'b00);
`endif
        hhit = 1'b0;
        lhit = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rem[i] = (cyc <= m_exp[i]) ? (m_exp[i] - cyc + 1) : 0;
            if (rem[i] > 0) begin
                if (iabs(int'(v.hk) - m_key[i]) <= int'(KEY_TOL) && int'(v.hq) <= m_q[i]) hhit = 1'b1;
                if (iabs(int'(v.lk) - m_key[i]) <= int'(KEY_TOL) && int'(v.lq) <= m_q[i]) lhit = 1'b1;
            end
        end
        hacc = v.hv && (byp || !hhit);
        lacc = v.lv && (byp || (!lhit && !(hacc && iabs(int'(v.hk) - int'(v.lk)) <= int'(KEY_TOL))));
        b  = 5'(m_bxn % 32);
        e0 = '0;
        e1 = '0;
        if (hacc) e0 = w(1'b1, v.hq, v.ha, v.hb, v.hk, b);
        if (hacc && lacc) e1 = w(1'b1, v.lq, v.la, v.lb, v.lk, b);
        else if (lacc)    e0 = w(1'b1, v.lq, v.la, v.lb, v.lk, b);
        m_sup += int'(v.hv && !hacc) + int'(v.lv && !lacc);
        if (m_sup > 65535) m_sup = 65535;
        if (hacc && lacc) begin
            m_key[0] = int'(v.hk); m_q[0] = int'(v.hq); m_exp[0] = cyc + int'(v.dt);
            m_key[1] = int'(v.lk); m_q[1] = int'(v.lq); m_exp[1] = cyc + int'(v.dt);
        end else if (hacc || lacc) begin
            tgt = (rem[1] < rem[0]) ? 1 : 0;
            m_key[tgt] = hacc ? int'(v.hk) : int'(v.lk);
            m_q[tgt]   = hacc ? int'(v.hq) : int'(v.lq);
            m_exp[tgt] = cyc + int'(v.dt);
        end
        es = v.sh;
        ec = 16'(m_sup);
        if (v.bc0) m_bxn = 0;
        else       m_bxn = (m_bxn == int'(BXN_MAX)) ? 0 : m_bxn + 1;
        cyc++;
    endtask

    task automatic drive(input in_t v);
        bus.hv = v.hv; bus.hp = v.hq; bus.hnp = v.hk; bus.hfap = v.ha; bus.hpatbp = v.hb;
        bus.lv = v.lv; bus.lp = v.lq; bus.lnp = v.lk; bus.lfap = v.la; bus.lpatbp = v.lb;
        bus.shower_int = v.sh; bus.dead_time = v.dt; bus.bc0 = v.bc0;
    endtask

    task automatic step(input in_t v, output logic [17:0] e0, output logic [17:0] e1,
                        output logic [1:0] es, output logic [15:0] ec);
        drive(v);
        model_step(v, e0, e1, es, ec);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [17:0] e0, e1;
        logic [1:0]  es;
        logic [15:0] ec;
        in_t         v;
        logic [3:0]  cur_dt;
        logic [17:0] z;
        z = '0;

        // Directed vectors: one row per clock; bxn bits are masked out.
        for (int i = 0; i < 5; i++)
            rows.push_back(mk_row(lct_in(1, 3, 40, 0, 0, 0, 0, 0, 0, 0, 0), w(1, 3, 0, 0, 40, 0), z, 0));
        rows.push_back(mk_row(lct_in(1, 2, 40, 1, 0, 0, 0, 0, 0, 0, 4), w(1, 2, 1, 0, 40, 0), z, 0));
        rows.push_back(mk_row(lct_in(1, 2, 41, 0, 0, 0, 0, 0, 0, 0, 4), z, z, 1));
        for (int i = 0; i < 3; i++) rows.push_back(mk_row(idle(4), z, z, 1));
        rows.push_back(mk_row(lct_in(1, 1, 40, 0, 1, 0, 0, 0, 0, 0, 4), w(1, 1, 0, 1, 40, 0), z, 1));
        rows.push_back(mk_row(lct_in(1, 3, 40, 0, 0, 0, 0, 0, 0, 0, 4), w(1, 3, 0, 0, 40, 0), z, 1));
        for (int i = 0; i < 4; i++) rows.push_back(mk_row(idle(4), z, z, 1));
        rows.push_back(mk_row(lct_in(1, 2, 40, 0, 0, 0, 0, 0, 0, 0, 4), w(1, 2, 0, 0, 40, 0), z, 1));
        rows.push_back(mk_row(idle(4), z, z, 1));
        rows.push_back(mk_row(lct_in(1, 2, 40, 0, 0, 1, 1, 90, 1, 0, 4), w(1, 1, 1, 0, 90, 0), z, 2));
        for (int i = 0; i < 4; i++) rows.push_back(mk_row(idle(4), z, z, 2));
        rows.push_back(mk_row(lct_in(1, 2, 40, 0, 0, 0, 0, 0, 0, 0, 2), w(1, 2, 0, 0, 40, 0), z, 2));
        rows.push_back(mk_row(idle(2), z, z, 2));
        rows.push_back(mk_row(lct_in(1, 2, 40, 0, 0, 0, 0, 0, 0, 0, 2), z, z, 3));
        rows.push_back(mk_row(lct_in(1, 2, 40, 0, 0, 0, 0, 0, 0, 0, 2), w(1, 2, 0, 0, 40, 0), z, 3));
        for (int i = 0; i < 2; i++) rows.push_back(mk_row(idle(2), z, z, 3));
        rows.push_back(mk_row(lct_in(1, 1, 20, 0, 0, 1, 2, 60, 0, 1, 0), w(1, 1, 0, 0, 20, 0), w(1, 2, 0, 1, 60, 0), 3));
        rows.push_back(mk_row(lct_in(1, 1, 20, 0, 0, 1, 3, 21, 0, 0, 0), w(1, 1, 0, 0, 20, 0), z, 4));
        rows.push_back(mk_row(lct_in(0, 2, 5, 0, 0, 1, 0, 70, 0, 0, 0), w(1, 0, 0, 0, 70, 0), z, 4));

        rst_n = 1'b0;
        drive(idle(0));
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_state", 64'({bus.lct0, bus.lct1, bus.shower_o, bus.suppressed_cnt}), 64'(0));
        #1 rst_n = 1'b1;

        foreach (rows[i]) begin
            step(rows[i].in, e0, e1, es, ec);
            check($sformatf("row%0d", i),
                  64'({bus.lct0 & MASK, bus.lct1 & MASK, bus.suppressed_cnt}),
                  64'({rows[i].e0, rows[i].e1, 16'(rows[i].sup)}));
        end

        // bc0 zeroes the counter for the following clock.
        v = idle(0); v.bc0 = 1'b1;
        step(v, e0, e1, es, ec);
        step(idle(0), e0, e1, es, ec);
        for (int b = 1; b <= 3; b++) begin
            step(lct_in(1, 3, 40, 0, 0, 0, 0, 0, 0, 0, 0), e0, e1, es, ec);
            check($sformatf("bxn_after_bc0_%0d", b), 64'(bus.lct0), 64'(w(1, 3, 0, 0, 40, 5'(b))));
        end
        v = idle(0); v.bc0 = 1'b1;
        step(v, e0, e1, es, ec);
        for (int i = 0; i < 3563; i++) step(idle(0), e0, e1, es, ec);
        step(lct_in(1, 3, 40, 0, 0, 0, 0, 0, 0, 0, 0), e0, e1, es, ec);
        check("bxn_max", 64'(bus.lct0), 64'(w(1, 3, 0, 0, 40, 5'd11)));
        step(lct_in(1, 3, 40, 0, 0, 0, 0, 0, 0, 0, 0), e0, e1, es, ec);
        check("bxn_wrap", 64'(bus.lct0), 64'(w(1, 3, 0, 0, 40, 5'd0)));

        // Async reset in the middle of traffic.
        v = lct_in(1, 2, 40, 0, 0, 0, 0, 0, 0, 0, 4); v.sh = 2'b10;
        step(v, e0, e1, es, ec);
        check("pre_reset", 64'({bus.lct0, bus.shower_o}), 64'({e0, es}));
        rst_n = 1'b0;
        #1;
        check("async_reset", 64'({bus.lct0, bus.lct1, bus.shower_o, bus.suppressed_cnt}), 64'(0));
        model_reset();
        #2 rst_n = 1'b1;
        step(lct_in(1, 2, 40, 0, 0, 0, 0, 0, 0, 0, 4), e0, e1, es, ec);
        check("post_reset_pass", 64'({bus.lct0, bus.suppressed_cnt}), 64'({w(1, 2, 0, 0, 40, 0), 16'd0}));
        step(lct_in(1, 2, 40, 0, 0, 0, 0, 0, 0, 0, 4), e0, e1, es, ec);
        check("post_reset_supp", 64'({bus.lct0, bus.suppressed_cnt}), 64'({18'd0, 16'd1}));

        // Randomized traffic on a narrow key range so tracks collide often.
        cur_dt = 4'd3;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 49) == 0) cur_dt = 4'($urandom_range(0, 5));
            v.hv  = 1'($urandom_range(0, 1));
            v.hq  = 2'($urandom_range(0, 3));
            v.hk  = 7'($urandom_range(36, 44));
            v.ha  = 1'($urandom_range(0, 1));
            v.hb  = 1'($urandom_range(0, 1));
            v.lv  = 1'($urandom_range(0, 1));
            v.lq  = 2'($urandom_range(0, 3));
            v.lk  = 7'($urandom_range(36, 44));
            v.la  = 1'($urandom_range(0, 1));
            v.lb  = 1'($urandom_range(0, 1));
            v.sh  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            v.dt  = cur_dt;
            v.bc0 = ($urandom_range(0, 99) == 0);
            step(v, e0, e1, es, ec);
            check($sformatf("rand%0d", n),
                  64'({bus.lct0, bus.lct1, bus.shower_o, bus.suppressed_cnt}),
                  64'({e0, e1, es, ec}));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
